// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target: command codes, register map,
// STATUS bit positions, phase lengths and the frame state encoding.
package spi_target_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_ADDR = 3'd2,
      ST_DOUT = 3'd3,
      ST_DIN  = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_ID    = 8'h9F;

   localparam logic [2:0] REG_STATUS  = 3'd0;
   localparam logic [2:0] REG_CTRL    = 3'd1;
   localparam logic [2:0] REG_TX_DATA = 3'd2;
   localparam logic [2:0] REG_RX_ADDR = 3'd3;
   localparam logic [2:0] REG_RX_DATA = 3'd4;
   localparam logic [2:0] REG_CMD     = 3'd5;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_WR_DONE = 1;
   localparam int STAT_RD_DONE = 2;
   localparam int STAT_OVERRUN = 3;

   localparam logic [5:0] CMD_BITS  = 6'd8;
   localparam logic [5:0] ADDR_BITS = 6'd24;
   localparam logic [5:0] DATA_BITS = 6'd32;

   // True when the bit being processed is the final bit of a phase of length len.
   function automatic logic phase_last(input logic [5:0] cnt, input logic [5:0] len);
      return (cnt == (len - 6'd1));
   endfunction

endpackage

// File: rtl/spi_target_shift.sv
// SPI frame engine: pin synchronisers, sck edge detection, frame state
// machine and shift registers. Reports decoded fields with one-cycle pulses.
module spi_target_shift
   import spi_target_pkg::*;
#(
   parameter logic [31:0] ID = 32'h5350_4954
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   input  logic        cs,
   input  logic        sck,
   input  logic        mosi,
   input  logic [31:0] tx_data,
   output logic        miso,
   output logic        busy,
   output logic [7:0]  cmd,
   output logic [23:0] addr,
   output logic [31:0] data,
   output logic        cmd_done,
   output logic        addr_done,
   output logic        wr_done,
   output logic        rd_done
);

   logic [1:0]  cs_ff_r, sck_ff_r, mosi_ff_r, vld_r;
   logic        sck_prev_r, armed_r, miso_r;
   state_t      state_r, state_nx_s;
   logic [5:0]  cnt_r;
   logic [6:0]  cmd_sr_r;
   logic [22:0] addr_sr_r;
   logic [30:0] din_sr_r;
   logic [31:0] tx_sr_r;
   logic [7:0]  cmd_r;
   logic [23:0] addr_r;
   logic [31:0] data_r;
   logic        cmd_done_r, addr_done_r, wr_done_r, rd_done_r;

   logic        cs_s, mosi_s, sck_rise_s, sck_fall_s, cnt_evt_s;
   logic        cmd_last_s, addr_last_s, din_last_s, dout_last_s;
   logic [7:0]  cmd_word_s;
   logic [23:0] addr_word_s;
   logic [31:0] din_word_s;

   assign cs_s        = cs_ff_r[1];
   assign mosi_s      = mosi_ff_r[1];
   assign sck_rise_s  = sck_ff_r[1] & ~sck_prev_r;
   assign sck_fall_s  = ~sck_ff_r[1] & sck_prev_r;
   assign cmd_word_s  = {cmd_sr_r, mosi_s};
   assign addr_word_s = {addr_sr_r, mosi_s};
   assign din_word_s  = {din_sr_r, mosi_s};

   assign miso      = miso_r;
   assign busy      = ~cs_s;
   assign cmd       = cmd_r;
   assign addr      = addr_r;
   assign data      = data_r;
   assign cmd_done  = cmd_done_r;
   assign addr_done = addr_done_r;
   assign wr_done   = wr_done_r;
   assign rd_done   = rd_done_r;

   // Two-stage synchronisers on the SPI pins; vld_r marks when they hold post-reset pin values
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         cs_ff_r    <= 2'b11;
         sck_ff_r   <= 2'b00;
         mosi_ff_r  <= 2'b00;
         sck_prev_r <= 1'b0;
         vld_r      <= 2'b00;
      end else begin
         cs_ff_r    <= {cs_ff_r[0], cs};
         sck_ff_r   <= {sck_ff_r[0], sck};
         mosi_ff_r  <= {mosi_ff_r[0], mosi};
         sck_prev_r <= sck_ff_r[1];
         vld_r      <= {vld_r[0], 1'b1};
      end
   end

   // Next-state decode and phase-end detection
   always_comb begin
      state_nx_s  = state_r;
      cmd_last_s  = 1'b0;
      addr_last_s = 1'b0;
      din_last_s  = 1'b0;
      dout_last_s = 1'b0;
      cnt_evt_s   = 1'b0;
      if ((state_r != ST_IDLE) && cs_s) begin
         state_nx_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (armed_r && !cs_s) state_nx_s = ST_CMD;
               else                  state_nx_s = ST_IDLE;
            end
            ST_CMD: begin
               cnt_evt_s = sck_rise_s;
               if (sck_rise_s && phase_last(cnt_r, CMD_BITS)) begin
                  cmd_last_s = 1'b1;
                  case (cmd_word_s)
                     CMD_READ, CMD_WRITE: state_nx_s = ST_ADDR;
                     CMD_ID:              state_nx_s = ST_DOUT;
                     default:             state_nx_s = ST_DONE;
                  endcase
               end else begin
                  state_nx_s = ST_CMD;
               end
            end
            ST_ADDR: begin
               cnt_evt_s = sck_rise_s;
               if (sck_rise_s && phase_last(cnt_r, ADDR_BITS)) begin
                  addr_last_s = 1'b1;
                  if (cmd_r == CMD_READ) state_nx_s = ST_DOUT;
                  else                   state_nx_s = ST_DIN;
               end else begin
                  state_nx_s = ST_ADDR;
               end
            end
            ST_DOUT: begin
               cnt_evt_s = sck_fall_s;
               if (sck_fall_s && phase_last(cnt_r, DATA_BITS)) begin
                  dout_last_s = 1'b1;
                  state_nx_s  = ST_DONE;
               end else begin
                  state_nx_s = ST_DOUT;
               end
            end
            ST_DIN: begin
               cnt_evt_s = sck_rise_s;
               if (sck_rise_s && phase_last(cnt_r, DATA_BITS)) begin
                  din_last_s = 1'b1;
                  state_nx_s = ST_DONE;
               end else begin
                  state_nx_s = ST_DIN;
               end
            end
            ST_DONE: state_nx_s = ST_DONE;
            default: state_nx_s = ST_IDLE;
         endcase
      end
   end

   // State register; a new frame needs cs seen high after reset or the previous frame
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state_r <= ST_IDLE;
         armed_r <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         if ((state_r == ST_IDLE) && (state_nx_s == ST_CMD)) armed_r <= 1'b0;
         else if (vld_r[1] && cs_s)                          armed_r <= 1'b1;
         else                                                armed_r <= armed_r;
      end
   end

   // Bit counter, shift registers, miso driver and completion outputs
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         cnt_r       <= 6'd0;
         cmd_sr_r    <= 7'd0;
         addr_sr_r   <= 23'd0;
         din_sr_r    <= 31'd0;
         tx_sr_r     <= 32'd0;
         miso_r      <= 1'b1;
         cmd_r       <= 8'd0;
         addr_r      <= 24'd0;
         data_r      <= 32'd0;
         cmd_done_r  <= 1'b0;
         addr_done_r <= 1'b0;
         wr_done_r   <= 1'b0;
         rd_done_r   <= 1'b0;
      end else begin
         if (state_nx_s != state_r) cnt_r <= 6'd0;
         else if (cnt_evt_s)        cnt_r <= cnt_r + 6'd1;

         if ((state_r == ST_CMD) && sck_rise_s)  cmd_sr_r  <= cmd_word_s[6:0];
         if ((state_r == ST_ADDR) && sck_rise_s) addr_sr_r <= addr_word_s[22:0];
         if ((state_r == ST_DIN) && sck_rise_s)  din_sr_r  <= din_word_s[30:0];

         // Reply word is captured only at entry to the data-out phase
         if (cmd_last_s && (cmd_word_s == CMD_ID))             tx_sr_r <= ID;
         else if (addr_last_s && (cmd_r == CMD_READ))          tx_sr_r <= tx_data;
         else if ((state_r == ST_DOUT) && sck_fall_s)          tx_sr_r <= {tx_sr_r[30:0], 1'b0};

         case (state_r)
            ST_DOUT: if (sck_fall_s) miso_r <= tx_sr_r[31];
            ST_DONE: if (sck_fall_s) miso_r <= 1'b1;
            default: miso_r <= 1'b1;
         endcase

         if (cmd_last_s)  cmd_r  <= cmd_word_s;
         if (addr_last_s) addr_r <= addr_word_s;
         if (din_last_s)  data_r <= din_word_s;

         cmd_done_r  <= cmd_last_s;
         addr_done_r <= addr_last_s && (cmd_r == CMD_READ);
         wr_done_r   <= din_last_s;
         rd_done_r   <= dout_last_s;
      end
   end

endmodule

// File: rtl/spi_target.sv
// SPI target peripheral: bus decode, CPU register file, read mux and
// interrupt, around the spi_target_shift frame engine.
module spi_target
   import spi_target_pkg::*;
#(
   parameter logic [31:0] ADDR   = 32'h0000_0000,
   parameter int          AWIDTH = 8,
   parameter logic [31:0] ID     = 32'h5350_4954
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   input  logic [31:0] wb_dbus_adr,
   input  logic [31:0] wb_dbus_dat,
   input  logic [3:0]  wb_dbus_sel,
   input  logic        wb_dbus_we,
   input  logic        wb_dbus_cyc,
   output logic [31:0] rdt,
   output logic        ack,
   input  logic        cs,
   input  logic        sck,
   input  logic        mosi,
   output logic        miso,
   output logic        irq
);

   logic        sel_s, wr_s, status_wr_s, unused_s;
   logic [2:0]  idx_s;
   logic        busy_s, sh_cmd_done_s, sh_addr_done_s, sh_wr_done_s, sh_rd_done_s;
   logic [7:0]  sh_cmd_s;
   logic [23:0] sh_addr_s;
   logic [31:0] sh_data_s;
   logic        irq_en_nx_s, wr_done_nx_s, rd_done_nx_s, ovr_nx_s;
   logic [31:0] rdt_s;

   logic        irq_en_r, wr_done_r, rd_done_r, ovr_r, irq_r;
   logic [31:0] tx_data_r, rx_data_r;
   logic [23:0] rx_addr_r;
   logic [7:0]  cmd_r;

   // Chip select: high-address decode; access is full-word only
   assign sel_s    = wb_dbus_cyc && (wb_dbus_adr[31 -: AWIDTH] == ADDR[AWIDTH-1:0]);
   assign wr_s     = sel_s && wb_dbus_we;
   assign idx_s    = wb_dbus_adr[4:2];
   assign ack      = sel_s;
   assign rdt      = rdt_s;
   assign irq      = irq_r;
   assign unused_s = ^{wb_dbus_sel, wb_dbus_adr};

   spi_target_shift #(.ID(ID)) u_shift (
      .wb_clk    (wb_clk),
      .wb_rst    (wb_rst),
      .cs        (cs),
      .sck       (sck),
      .mosi      (mosi),
      .tx_data   (tx_data_r),
      .miso      (miso),
      .busy      (busy_s),
      .cmd       (sh_cmd_s),
      .addr      (sh_addr_s),
      .data      (sh_data_s),
      .cmd_done  (sh_cmd_done_s),
      .addr_done (sh_addr_done_s),
      .wr_done   (sh_wr_done_s),
      .rd_done   (sh_rd_done_s)
   );

   // Flag and control next values; a hardware set beats a same-cycle clear
   always_comb begin
      status_wr_s = wr_s && (idx_s == REG_STATUS);

      if (sh_wr_done_s)                                     wr_done_nx_s = 1'b1;
      else if (status_wr_s && wb_dbus_dat[STAT_WR_DONE])    wr_done_nx_s = 1'b0;
      else                                                  wr_done_nx_s = wr_done_r;

      if (sh_rd_done_s)                                     rd_done_nx_s = 1'b1;
      else if (status_wr_s && wb_dbus_dat[STAT_RD_DONE])    rd_done_nx_s = 1'b0;
      else                                                  rd_done_nx_s = rd_done_r;

      if (sh_wr_done_s && wr_done_r)                        ovr_nx_s = 1'b1;
      else if (status_wr_s && wb_dbus_dat[STAT_OVERRUN])    ovr_nx_s = 1'b0;
      else                                                  ovr_nx_s = ovr_r;

      if (wr_s && (idx_s == REG_CTRL))                      irq_en_nx_s = wb_dbus_dat[0];
      else                                                  irq_en_nx_s = irq_en_r;
   end

   // Register file, received-frame capture and registered interrupt
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         irq_en_r  <= 1'b0;
         wr_done_r <= 1'b0;
         rd_done_r <= 1'b0;
         ovr_r     <= 1'b0;
         irq_r     <= 1'b0;
         tx_data_r <= 32'd0;
         rx_addr_r <= 24'd0;
         rx_data_r <= 32'd0;
         cmd_r     <= 8'd0;
      end else begin
         irq_en_r  <= irq_en_nx_s;
         wr_done_r <= wr_done_nx_s;
         rd_done_r <= rd_done_nx_s;
         ovr_r     <= ovr_nx_s;
         irq_r     <= irq_en_nx_s & (wr_done_nx_s | rd_done_nx_s | ovr_nx_s);
         if (wr_s && (idx_s == REG_TX_DATA)) tx_data_r <= wb_dbus_dat;
         if (sh_cmd_done_s) cmd_r <= sh_cmd_s;
         if (sh_wr_done_s) begin
            rx_addr_r <= sh_addr_s;
            rx_data_r <= sh_data_s;
         end else if (sh_addr_done_s) begin
            rx_addr_r <= sh_addr_s;
         end
      end
   end

   // Combinational read mux, zero when not selected
   always_comb begin
      rdt_s = 32'd0;
      if (sel_s) begin
         case (idx_s)
            REG_STATUS:  rdt_s = {28'd0, ovr_r, rd_done_r, wr_done_r, busy_s};
            REG_CTRL:    rdt_s = {31'd0, irq_en_r};
            REG_TX_DATA: rdt_s = tx_data_r;
            REG_RX_ADDR: rdt_s = {8'd0, rx_addr_r};
            REG_RX_DATA: rdt_s = rx_data_r;
            REG_CMD:     rdt_s = {24'd0, cmd_r};
            default:     rdt_s = 32'd0;
         endcase
      end else begin
         rdt_s = 32'd0;
      end
   end

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: an SPI master drives frames while a
// register-level model of the peripheral predicts replies and CPU-visible state.
module tb_spi_target;

   localparam int          HALF   = 6;
   localparam logic [31:0] ID_VAL = 32'h5350_4954;
   localparam logic [2:0]  R_STAT = 3'd0, R_CTRL = 3'd1, R_TX = 3'd2,
                           R_RXA  = 3'd3, R_RXD  = 3'd4, R_CMD = 3'd5;

   logic        wb_clk = 1'b0;
   logic        wb_rst;
   logic [31:0] wb_dbus_adr, wb_dbus_dat, rdt;
   logic [3:0]  wb_dbus_sel;
   logic        wb_dbus_we, wb_dbus_cyc, ack;
   logic        cs, sck, mosi, miso, irq;

   int total = 0;
   int bad   = 0;
   logic rxq[$];

   // Reference model of CPU-visible state
   logic [31:0] m_tx, m_rx_data;
   logic [23:0] m_rx_addr;
   logic [7:0]  m_cmd;
   logic        m_ien, m_wr, m_rd, m_ovr;

   spi_target dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst),
      .wb_dbus_adr(wb_dbus_adr), .wb_dbus_dat(wb_dbus_dat), .wb_dbus_sel(wb_dbus_sel),
      .wb_dbus_we(wb_dbus_we), .wb_dbus_cyc(wb_dbus_cyc),
      .rdt(rdt), .ack(ack),
      .cs(cs), .sck(sck), .mosi(mosi), .miso(miso), .irq(irq)
   );

   always #5 wb_clk = ~wb_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_tx = 32'd0; m_rx_data = 32'd0; m_rx_addr = 24'd0; m_cmd = 8'd0;
      m_ien = 1'b0; m_wr = 1'b0; m_rd = 1'b0; m_ovr = 1'b0;
   endtask

   task automatic bus_write(input logic [2:0] idx, input logic [31:0] d);
      wb_dbus_adr = {27'd0, idx, 2'b00};
      wb_dbus_dat = d;
      wb_dbus_we  = 1'b1;
      wb_dbus_cyc = 1'b1;
      @(posedge wb_clk); #1;
      wb_dbus_cyc = 1'b0;
      wb_dbus_we  = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic k);
      wb_dbus_adr = a;
      wb_dbus_we  = 1'b0;
      wb_dbus_cyc = 1'b1;
      #2;
      d = rdt;
      k = ack;
      @(posedge wb_clk); #1;
      wb_dbus_cyc = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [2:0] idx, input logic [31:0] exp);
      logic [31:0] d;
      logic        k;
      bus_read({27'd0, idx, 2'b00}, d, k);
      check(tag, d, exp);
   endtask

   // All CPU-visible registers against the model (cs is high, so not busy)
   task automatic check_regs(input string tag);
      check_reg({tag, ".status"}, R_STAT, {28'd0, m_ovr, m_rd, m_wr, 1'b0});
      check_reg({tag, ".ctrl"},   R_CTRL, {31'd0, m_ien});
      check_reg({tag, ".tx"},     R_TX,   m_tx);
      check_reg({tag, ".rxaddr"}, R_RXA,  {8'd0, m_rx_addr});
      check_reg({tag, ".rxdata"}, R_RXD,  m_rx_data);
      check_reg({tag, ".cmd"},    R_CMD,  {24'd0, m_cmd});
   endtask

   task automatic check_irq(input string tag);
      repeat (2) @(posedge wb_clk);
      #1;
      check(tag, {31'd0, irq}, {31'd0, m_ien & (m_wr | m_rd | m_ovr)});
   endtask

   task automatic cs_low();
      rxq.delete();
      cs = 1'b0;
      repeat (HALF) @(posedge wb_clk);
      #1;
   endtask

   task automatic cs_high();
      repeat (HALF) @(posedge wb_clk);
      #1;
      cs = 1'b1;
      repeat (8) @(posedge wb_clk);
      #1;
   endtask

   // Shift the low n bits of val out MSB-first; record miso as seen at each falling edge
   task automatic spi_bits(input logic [63:0] val, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         mosi = val[i];
         repeat (HALF) @(posedge wb_clk);
         #1;
         sck = 1'b1;
         repeat (HALF) @(posedge wb_clk);
         #1;
         rxq.push_back(miso);
         sck = 1'b0;
      end
   endtask

   function automatic logic [31:0] word_at(input int h);
      logic [31:0] w;
      w = 32'd0;
      for (int k = 0; k < 32; k++) w = {w[30:0], rxq[h + k]};
      return w;
   endfunction

   function automatic logic [31:0] ones_seen();
      logic all1;
      all1 = 1'b1;
      foreach (rxq[k]) all1 = all1 & rxq[k];
      return {31'd0, all1};
   endfunction

   task automatic run_id(input string tag);
      cs_low();
      spi_bits({24'd0, 8'h9F, 32'd0}, 40);
      cs_high();
      check({tag, ".word"}, word_at(8), ID_VAL);
      m_cmd = 8'h9F;
      m_rd  = 1'b1;
   endtask

   task automatic run_read(input string tag, input logic [23:0] a, input bit mid, input logic [31:0] nv);
      logic [31:0] expw;
      expw = m_tx;
      cs_low();
      spi_bits({16'd0, 8'h03, a, 16'd0}, 48);
      if (mid) begin
         bus_write(R_TX, nv);
         m_tx = nv;
      end
      spi_bits(64'd0, 16);
      cs_high();
      check({tag, ".word"}, word_at(32), expw);
      m_cmd     = 8'h03;
      m_rx_addr = a;
      m_rd      = 1'b1;
   endtask

   task automatic run_write(input string tag, input logic [23:0] a, input logic [31:0] d);
      cs_low();
      spi_bits({8'h02, a, d}, 64);
      cs_high();
      check({tag, ".miso_ones"}, ones_seen(), 32'd1);
      if (m_wr) m_ovr = 1'b1;
      m_wr      = 1'b1;
      m_cmd     = 8'h02;
      m_rx_addr = a;
      m_rx_data = d;
   endtask

   initial begin
      logic [31:0] d;
      logic        k;
      logic [23:0] ra;

      cs = 1'b1; sck = 1'b0; mosi = 1'b0;
      wb_dbus_adr = 32'd0; wb_dbus_dat = 32'd0; wb_dbus_sel = 4'hF;
      wb_dbus_we = 1'b0; wb_dbus_cyc = 1'b0;
      wb_rst = 1'b1;
      repeat (5) @(posedge wb_clk);
      #1;
      wb_rst = 1'b0;
      model_reset();
      repeat (4) @(posedge wb_clk);
      #1;

      // Reset state
      check("reset.miso", {31'd0, miso}, 32'd1);
      check("reset.irq", {31'd0, irq}, 32'd0);
      check_regs("reset");
      check_reg("reset.reg6", 3'd6, 32'd0);
      check_reg("reset.reg7", 3'd7, 32'd0);
      bus_write(R_TX, 32'h1234_5678);
      m_tx = 32'h1234_5678;
      bus_read(32'h0100_0008, d, k);
      check("unselected.rdt", d, 32'd0);
      check("unselected.ack", {31'd0, k}, 32'd0);

      // ID command
      run_id("id");
      check_regs("id");
      bus_write(R_STAT, 32'h4);
      m_rd = 1'b0;

      // READ with a CPU update of TX_DATA during the data phase
      bus_write(R_TX, 32'hDEAD_BEEF);
      m_tx = 32'hDEAD_BEEF;
      run_read("read", 24'h123456, 1'b1, $urandom);
      check_regs("read");
      for (int n = 0; n < 2; n++) begin
         bus_write(R_TX, $urandom);
         m_tx = 32'd0;
         bus_read({27'd0, R_TX, 2'b00}, d, k);
         m_tx = d;
         ra = 24'($urandom);
         run_read("read_rand", ra, 1'b0, 32'd0);
         check_regs("read_rand");
      end

      // WRITE with interrupt, W1C, then overrun
      bus_write(R_STAT, 32'hE);
      m_wr = 1'b0; m_rd = 1'b0; m_ovr = 1'b0;
      bus_write(R_CTRL, 32'h1);
      m_ien = 1'b1;
      check_irq("irq_none");
      run_write("write", 24'h000100, 32'hCAFE_F00D);
      check_regs("write");
      check_irq("irq_set");
      bus_write(R_STAT, 32'h2);
      m_wr = 1'b0;
      check_irq("irq_clr");
      run_write("write2", 24'($urandom), $urandom);
      run_write("write3", 24'($urandom), $urandom);
      check_regs("overrun");
      check_irq("irq_ovr");

      // Abort after 12 address bits, then a normal frame
      bus_write(R_STAT, 32'hE);
      m_wr = 1'b0; m_rd = 1'b0; m_ovr = 1'b0;
      cs_low();
      spi_bits({44'd0, 8'h03, 12'hABC}, 20);
      cs_high();
      m_cmd = 8'h03;
      check_regs("abort");
      check_irq("abort.irq");
      run_write("post_abort", 24'($urandom), $urandom);
      check_regs("post_abort");

      // Unknown command with a full data-length tail
      bus_write(R_STAT, 32'hE);
      m_wr = 1'b0; m_rd = 1'b0; m_ovr = 1'b0;
      cs_low();
      spi_bits({24'd0, 8'h55, 32'($urandom)}, 40);
      cs_high();
      check("unknown.miso_ones", ones_seen(), 32'd1);
      m_cmd = 8'h55;
      check_regs("unknown");

      // Reset in the middle of a frame: no decoding until cs is seen high again
      cs_low();
      spi_bits({44'd0, 8'h02, 12'h001}, 20);
      wb_rst = 1'b1;
      repeat (3) @(posedge wb_clk);
      #1;
      wb_rst = 1'b0;
      model_reset();
      rxq.delete();
      spi_bits({24'd0, 8'h9F, 32'd0}, 40);
      check("rst_mid.miso_ones", ones_seen(), 32'd1);
      cs_high();
      check_regs("rst_mid");
      run_id("post_rst");
      check_regs("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Overall time bound
   initial begin
      #3000000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
